// File: rtl/instr_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package instr_fetch_pkg;

    localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;
    localparam logic [31:0] PC_INC        = 32'd4;
    localparam logic [15:0] FETCH_CNT_MAX = 16'hFFFF;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    // Branch targets are forced onto a word boundary; the low bits only feed the error flag.
    function automatic logic [31:0] align_target(input logic [31:0] target);
        return {target[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_mem.sv
// Instruction memory: combinational read port for fetch, synchronous preload write port.
module instr_memory #(
    parameter int MEM_DEPTH = 16,
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [31:0]          wr_data,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [31:0]          rd_data
);

    logic [31:0] mem_q [MEM_DEPTH];

    // No reset: contents survive a fetch-stage reset, and a same-cycle read sees the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and fetch counter.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int MEM_DEPTH = 16,
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 pc_source,
    input  logic [31:0]          pc_branch,
    input  logic                 imem_we,
    input  logic [ADDR_BITS-1:0] imem_addr,
    input  logic [31:0]          imem_wdata,
    output logic [31:0]          pc,
    output logic [31:0]          if_pc,
    output logic [31:0]          if_pc_next,
    output logic [31:0]          if_instr,
    output logic                 if_valid,
    output logic                 misalign_err,
    output logic [15:0]          fetch_cnt
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic [31:0]  if_pc_next_q, if_pc_next_d;
    logic [31:0]  if_instr_q, if_instr_d;
    logic         if_valid_q, if_valid_d;
    logic         misalign_err_q, misalign_err_d;
    logic [15:0]  fetch_cnt_q, fetch_cnt_d;
    logic [31:0]  imem_rdata;

    instr_memory #(
        .MEM_DEPTH(MEM_DEPTH),
        .ADDR_BITS(ADDR_BITS)
    ) instruction_memory (
        .clk    (clk),
        .we     (imem_we),
        .wr_addr(imem_addr),
        .wr_data(imem_wdata),
        .rd_addr(pc_q[ADDR_BITS+1:2]),
        .rd_data(imem_rdata)
    );

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        if_pc_d        = if_pc_q;
        if_pc_next_d   = if_pc_next_q;
        if_instr_d     = if_instr_q;
        if_valid_d     = if_valid_q;
        misalign_err_d = misalign_err_q;
        fetch_cnt_d    = fetch_cnt_q;

        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                // A taken branch wins over stall and leaves exactly one bubble in IF/ID.
                if (pc_source) begin
                    pc_d       = align_target(pc_branch);
                    if_valid_d = 1'b0;
                    if_instr_d = NOP_INSTR;
                    if (pc_branch[1:0] != 2'b00) begin
                        misalign_err_d = 1'b1;
                    end
                end else if (!stall) begin
                    if_instr_d   = imem_rdata;
                    if_pc_d      = pc_q;
                    if_pc_next_d = pc_q + PC_INC;
                    if_valid_d   = 1'b1;
                    pc_d         = pc_q + PC_INC;
                    if (fetch_cnt_q != FETCH_CNT_MAX) begin
                        fetch_cnt_d = fetch_cnt_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= BOOT;
            pc_q           <= '0;
            if_pc_q        <= '0;
            if_pc_next_q   <= '0;
            if_instr_q     <= NOP_INSTR;
            if_valid_q     <= 1'b0;
            misalign_err_q <= 1'b0;
            fetch_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            if_pc_q        <= if_pc_d;
            if_pc_next_q   <= if_pc_next_d;
            if_instr_q     <= if_instr_d;
            if_valid_q     <= if_valid_d;
            misalign_err_q <= misalign_err_d;
            fetch_cnt_q    <= fetch_cnt_d;
        end
    end

    assign pc           = pc_q;
    assign if_pc        = if_pc_q;
    assign if_pc_next   = if_pc_next_q;
    assign if_instr     = if_instr_q;
    assign if_valid     = if_valid_q;
    assign misalign_err = misalign_err_q;
    assign fetch_cnt    = fetch_cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized and directed bench for instr_fetch, checked against a behavioural fetch model.
module tb_instr_fetch;

    localparam int MEM_DEPTH = 16;
    localparam int ADDR_BITS = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 stall;
    logic                 pc_source;
    logic [31:0]          pc_branch;
    logic                 imem_we;
    logic [ADDR_BITS-1:0] imem_addr;
    logic [31:0]          imem_wdata;
    logic [31:0]          pc;
    logic [31:0]          if_pc;
    logic [31:0]          if_pc_next;
    logic [31:0]          if_instr;
    logic                 if_valid;
    logic                 misalign_err;
    logic [15:0]          fetch_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [31:0] m_mem [MEM_DEPTH];
    bit          m_boot;
    logic [31:0] m_pc, m_if_pc, m_if_pc_next, m_instr;
    logic        m_valid, m_err;
    int          m_cnt;

    instr_fetch #(
        .MEM_DEPTH(MEM_DEPTH),
        .ADDR_BITS(ADDR_BITS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .pc_source   (pc_source),
        .pc_branch   (pc_branch),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .pc          (pc),
        .if_pc       (if_pc),
        .if_pc_next  (if_pc_next),
        .if_instr    (if_instr),
        .if_valid    (if_valid),
        .misalign_err(misalign_err),
        .fetch_cnt   (fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock of stimulus: the model advances from the same inputs, then all outputs are compared.
    task automatic applyStimulus(input bit rst, input bit st, input bit src, input logic [31:0] br,
                                 input bit we, input int wa, input logic [31:0] wd, input bit do_check);
        reset      = rst;
        stall      = st;
        pc_source  = src;
        pc_branch  = br;
        imem_we    = we;
        imem_addr  = ADDR_BITS'(wa);
        imem_wdata = wd;
        @(posedge clk);
        if (rst) begin
            m_boot = 1'b1; m_pc = 0; m_if_pc = 0; m_if_pc_next = 0;
            m_instr = 0; m_valid = 0; m_err = 0; m_cnt = 0;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (src) begin
            if (br % 4 != 0) m_err = 1'b1;
            m_pc    = br - (br % 4);
            m_valid = 1'b0;
            m_instr = 32'h0;
        end else if (!st) begin
            m_instr      = m_mem[(m_pc / 4) % MEM_DEPTH];
            m_if_pc      = m_pc;
            m_if_pc_next = m_pc + 32'd4;
            m_valid      = 1'b1;
            m_pc         = m_pc + 32'd4;
            if (m_cnt < 65535) m_cnt++;
        end
        if (we) m_mem[wa % MEM_DEPTH] = wd;
        #1;
        if (do_check) begin
            checkOutput("pc",           pc,                   m_pc);
            checkOutput("if_pc",        if_pc,                m_if_pc);
            checkOutput("if_pc_next",   if_pc_next,           m_if_pc_next);
            checkOutput("if_instr",     if_instr,             m_instr);
            checkOutput("if_valid",     {31'b0, if_valid},    {31'b0, m_valid});
            checkOutput("misalign_err", {31'b0, misalign_err}, {31'b0, m_err});
            checkOutput("fetch_cnt",    {16'b0, fetch_cnt},   32'(m_cnt));
        end
    endtask

    task automatic run(input bit st, input bit src, input logic [31:0] br);
        applyStimulus(1'b0, st, src, br, 1'b0, 0, 32'h0, 1'b1);
    endtask

    initial begin
        logic [31:0] rbr;
        bit          rst_r, st_r, src_r, we_r;

        // Preload the whole memory while held in reset.
        for (int i = 0; i < MEM_DEPTH; i++) begin
            logic [31:0] w;
            w = (i < 4) ? 32'(i + 1) * 32'h11 : 32'h100 + 32'(i);
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, i, w, 1'b1);
        end
        checkOutput("reset_valid", {31'b0, if_valid}, 32'h0);

        run(1'b0, 1'b0, 32'h0);
        checkOutput("boot_bubble", {31'b0, if_valid}, 32'h0);
        run(1'b0, 1'b0, 32'h0);
        checkOutput("first_instr", if_instr, 32'h11);
        run(1'b0, 1'b0, 32'h0);
        checkOutput("second_pc", if_pc, 32'h4);
        checkOutput("pc_at_8", pc, 32'h8);

        // Taken branch back to 0x4, then sequential fetch again.
        run(1'b0, 1'b1, 32'h4);
        checkOutput("branch_pc", pc, 32'h4);
        run(1'b0, 1'b0, 32'h0);
        checkOutput("post_branch_instr", if_instr, 32'h22);
        run(1'b0, 1'b0, 32'h0);
        checkOutput("third_instr", if_instr, 32'h33);

        // Stall at 0xC, a write during stall, then stall together with a branch.
        run(1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 5, 32'h555, 1'b1);
        run(1'b1, 1'b0, 32'h0);
        checkOutput("stall_pc", pc, 32'hC);
        run(1'b1, 1'b1, 32'h0);
        checkOutput("stall_branch_pc", pc, 32'h0);
        run(1'b0, 1'b0, 32'h0);
        checkOutput("cnt_five", {16'b0, fetch_cnt}, 32'd5);

        // Reset mid-run, memory preserved.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 0, 32'h0, 1'b1);
        checkOutput("midrun_reset_cnt", {16'b0, fetch_cnt}, 32'h0);
        run(1'b0, 1'b0, 32'h0);
        run(1'b0, 1'b0, 32'h0);
        checkOutput("mem_kept", if_instr, 32'h11);

        // Misaligned target, sticky flag.
        run(1'b0, 1'b1, 32'h6);
        checkOutput("misalign_pc", pc, 32'h4);
        for (int i = 0; i < 3; i++) run(1'b0, 1'b0, 32'h0);
        checkOutput("misalign_sticky", {31'b0, misalign_err}, 32'h1);

        // Aliasing past the end of memory, then PC wrap at 2^32.
        run(1'b0, 1'b1, 32'h3C);
        run(1'b0, 1'b0, 32'h0);
        checkOutput("word15", if_instr, 32'h10F);
        run(1'b0, 1'b0, 32'h0);
        checkOutput("alias_word0", if_instr, 32'h11);
        run(1'b0, 1'b1, 32'hFFFF_FFFC);
        run(1'b0, 1'b0, 32'h0);
        checkOutput("wrap_pc", pc, 32'h0);

        // Same-cycle write and fetch of word 0 returns the old word; the next visit sees the new one.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 0, 32'hAA, 1'b1);
        checkOutput("old_on_collision", if_instr, 32'h11);
        run(1'b0, 1'b1, 32'h0);
        run(1'b0, 1'b0, 32'h0);
        checkOutput("new_after_write", if_instr, 32'hAA);

        // Randomized phase.
        for (int i = 0; i < 400; i++) begin
            rst_r = ($urandom_range(0, 49) == 0);
            st_r  = ($urandom_range(0, 3) == 0);
            src_r = ($urandom_range(0, 6) == 0);
            we_r  = ($urandom_range(0, 4) == 0);
            rbr   = $urandom;
            if ($urandom_range(0, 3) != 0) rbr[1:0] = 2'b00;
            applyStimulus(rst_r, st_r, src_r, rbr, we_r, int'($urandom_range(0, MEM_DEPTH - 1)),
                          $urandom, 1'b1);
        end

        // Saturation of the fetch counter.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 0, 32'h0, 1'b1);
        for (int i = 0; i < 65540; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 0, 32'h0, (i > 65530));
        end
        checkOutput("cnt_saturated", {16'b0, fetch_cnt}, 32'hFFFF);
        run(1'b0, 1'b1, 32'h8);
        run(1'b0, 1'b0, 32'h0);
        checkOutput("cnt_still_sat", {16'b0, fetch_cnt}, 32'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
